// File: rtl/atan_qfold.sv
// atan_qfold: quadrant-folding front end for a combinational CORDIC arctan core.
// Optional macro ATAN_QFOLD_ZERO_EN flags (0,0) inputs via out_zero with a forced zero angle.
module atan_qfold #(
  parameter int DEPTH    = 4,
  parameter int ANG_FRAC = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  input  logic [31:0] core_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_angle,
  output logic        out_zero
);
  // state | meaning            (same encoding for stage F and stage R)
  // EMPTY | no vector held
  // FULL  | holds a vector / result
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic signed [33:0] HALF  = 34'sd180 <<< ANG_FRAC;
  localparam logic signed [33:0] NHALF = -HALF;
  localparam logic signed [33:0] TURN  = 34'sd360 <<< ANG_FRAC;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam logic [31:0] MAX_INT = 32'h7fff_ffff;

  logic [31:0]   mem_x [DEPTH];
  logic [31:0]   mem_y [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          live;
  stage_t        f_state, f_next, r_state, r_next;
  logic signed [33:0] f_corr;
  logic          push, pop, fifo_empty, f_adv, r_drain;
  logic [31:0]   hx, hy, fx, fy;
  logic signed [33:0] fcorr_d, wrapped;

  assign fifo_empty = (count == '0);
  assign in_ready   = live && (count != FIFO_FULL);
  assign push       = in_valid && in_ready;
  assign f_adv      = (f_state == FULL) && ((r_state == EMPTY) || out_ready);
  assign pop        = !fifo_empty && ((f_state == EMPTY) || f_adv);
  assign r_drain    = (r_state == FULL) && out_ready;
  assign out_valid  = (r_state == FULL);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= in_x;
      mem_y[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Fold the FIFO head into the right half-plane; -2^31 negates to 2^31-1.
  always_comb begin
    hx      = mem_x[rd_ptr];
    hy      = mem_y[rd_ptr];
    fx      = hx;
    fy      = hy;
    fcorr_d = '0;
    if (hx[31]) begin
      fx      = (hx == MIN_INT) ? MAX_INT : (~hx + 32'd1);
      fy      = (hy == MIN_INT) ? MAX_INT : (~hy + 32'd1);
      fcorr_d = hy[31] ? NHALF : HALF;
    end
  end

  always_comb begin
    f_next = f_state;
    r_next = r_state;
    case (f_state)
      EMPTY:   if (pop) f_next = FULL;
      FULL:    if (f_adv && !pop) f_next = EMPTY;
      default: f_next = EMPTY;
    endcase
    case (r_state)
      EMPTY:   if (f_adv) r_next = FULL;
      FULL:    if (r_drain && !f_adv) r_next = EMPTY;
      default: r_next = EMPTY;
    endcase
  end

  // Two wrap steps cover any 32-bit core angle plus the half-turn correction.
  always_comb begin
    wrapped = {{2{core_angle[31]}}, core_angle} + f_corr;
    for (int i = 0; i < 2; i++) begin
      if (wrapped > HALF)        wrapped = wrapped - TURN;
      else if (wrapped <= NHALF) wrapped = wrapped + TURN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state <= EMPTY;
      r_state <= EMPTY;
    end else begin
      f_state <= f_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x <= '0;
      core_y <= '0;
      f_corr <= '0;
    end else if (pop) begin
      core_x <= fx;
      core_y <= fy;
      f_corr <= fcorr_d;
    end
  end

`ifdef ATAN_QFOLD_ZERO_EN
  logic f_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_zero    <= 1'b0;
      out_angle <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (pop) f_zero <= (hx == '0) && (hy == '0);
      if (f_adv) begin
        out_angle <= f_zero ? 32'd0 : wrapped[31:0];
        out_zero  <= f_zero;
      end
    end
  end
`else
  assign out_zero = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_angle <= '0;
    else if (f_adv) out_angle <= wrapped[31:0];
  end
`endif
endmodule
